// File: rtl/rv32i_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_regfile_wr_arbiter
//   Shares the single register-file write port between NREQ writeback
//   requesters with round-robin arbitration (valid/ready), and keeps a
//   32-entry pending-write scoreboard for RAW hazard detection at issue.
//
//   Parameters: XLEN (write data width), NREQ (requesters, 2..4)
//
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     req_valid/ready per-requester handshake (ready is one-hot or zero)
//     req_rd/req_data packed per-requester destination and write data
//     claim_valid/rd  issue stage reserves a destination register
//     rf_we/waddr/    register-file write port, one cycle after the grant
//     rf_wdata
//     busy            scoreboard, bit r = write to xr outstanding
//
//   Optional feature, macro RF_WR_ARB_PERF_EN: adds perf_grant_cnt, one
//   saturating 16-bit grant counter per requester (x0 grants included).
// ---------------------------------------------------------------------------
module rv32i_regfile_wr_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*5-1:0]    req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 claim_valid,
    input  logic [4:0]           claim_rd,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [31:0]          busy
`ifdef RF_WR_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]   perf_grant_cnt
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] scan_sel;
    int               scan_idx;
    logic             gnt_found;
    logic [NREQ-1:0]  gnt_onehot;
    logic [4:0]       gnt_rd;
    logic [XLEN-1:0]  gnt_data;
    logic [31:0]      busy_next;
    logic [4:0]       rd_arr   [NREQ];
    logic [XLEN-1:0]  data_arr [NREQ];

    // Unpack the flat requester buses so the winner can be indexed directly.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rd_arr[i]   = req_rd[i*5 +: 5];
            data_arr[i] = req_data[i*XLEN +: XLEN];
        end
    end

    // Round-robin scan: start at ptr, wrap modulo NREQ, first valid wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        scan_sel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            scan_sel = PTR_W'(scan_idx);
            if (!gnt_found && req_valid[scan_sel]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_sel;
            end
        end
    end

    always_comb begin
        gnt_onehot          = '0;
        gnt_onehot[gnt_idx] = gnt_found;
        // Ready is forced low during reset so no transfer can complete then.
        req_ready = rst ? '0 : gnt_onehot;
        gnt_rd    = rd_arr[gnt_idx];
        gnt_data  = data_arr[gnt_idx];
        ptr_next  = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Scoreboard update: clear on grant first, then a claim to the same
    // register overrides it because the claim is the newer reservation.
    always_comb begin
        busy_next = busy;
        if (gnt_found) begin
            busy_next[gnt_rd] = 1'b0;
        end
        if (claim_valid && (claim_rd != 5'd0)) begin
            busy_next[claim_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Grant -> register-file write stage (one cycle latency)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= '0;
        end else begin
            busy  <= busy_next;
            // x0 writes complete the handshake but never reach the file.
            rf_we <= gnt_found && (gnt_rd != 5'd0);
            if (gnt_found) begin
                ptr <= ptr_next;
                if (gnt_rd != 5'd0) begin
                    rf_waddr <= gnt_rd;
                    rf_wdata <= gnt_data;
                end
            end
        end
    end

`ifdef RF_WR_ARB_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] perf_cnt [NREQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                perf_cnt[i] <= '0;
            end
        end else if (gnt_found) begin
            perf_cnt[gnt_idx] <= sat_inc16(perf_cnt[gnt_idx]);
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            perf_grant_cnt[i*16 +: 16] = perf_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32i_regfile_wr_arbiter
//   Directed bench for rv32i_regfile_wr_arbiter (XLEN=32, NREQ=2). A
//   behavioural model of the arbiter/scoreboard is compared with the DUT on
//   every falling edge; directed steps add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_rv32i_regfile_wr_arbiter;

    localparam int XLEN = 32;
    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*5-1:0] req_rd = '0;
    logic [NREQ*XLEN-1:0] req_data = '0;
    logic              claim_valid = 1'b0;
    logic [4:0]        claim_rd = '0;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [31:0]       busy;
`ifdef RF_WR_ARB_PERF_EN
    logic [NREQ*16-1:0] perf_grant_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rv32i_regfile_wr_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rd         (req_rd),
        .req_data       (req_data),
        .claim_valid    (claim_valid),
        .claim_rd       (claim_rd),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy)
`ifdef RF_WR_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          ptr_m   = 0;
    bit          we_m    = 1'b0;
    logic [4:0]  waddr_m = '0;
    logic [31:0] wdata_m = '0;
    logic [31:0] busy_m  = '0;
    int          cnt_m [NREQ];

    function automatic int pick();
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (ptr_m + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g;
        if (rst) return '0;
        g = pick();
        if (g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        logic [4:0] rd;
        if (rst) begin
            ptr_m = 0; we_m = 1'b0; waddr_m = '0; wdata_m = '0; busy_m = '0;
            for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
        end else begin
            g = pick();
            we_m = 1'b0;
            if (g >= 0) begin
                rd = req_rd[g*5 +: 5];
                if (rd != 5'd0) begin
                    we_m = 1'b1;
                    waddr_m = rd;
                    wdata_m = req_data[g*XLEN +: XLEN];
                end
                busy_m[rd] = 1'b0;
                ptr_m = (g + 1) % NREQ;
                if (cnt_m[g] < 65535) cnt_m[g] = cnt_m[g] + 1;
            end
            if (claim_valid && claim_rd != 5'd0) busy_m[claim_rd] = 1'b1;
            busy_m[0] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", req_ready, exp_ready());
            check("model_rf_we", rf_we, we_m);
            check("model_rf_waddr", rf_waddr, waddr_m);
            check("model_rf_wdata", rf_wdata, wdata_m);
            check("model_busy", busy, busy_m);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1);
        req_valid = v;
        req_rd    = {r1, r0};
        req_data  = {d1, d0};
    endtask

    logic [1:0] exp_r [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [4:0] exp_a [4] = '{5'd5, 5'd6, 5'd5, 5'd6};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        drive(2'b11, 5'd5, 32'h11, 5'd6, 32'h22);
        #12 chk_en = 1'b1;
        tick(); tick();
        // reset state
        check("reset_ready", req_ready, 2'b00);
        check("reset_rf_we", rf_we, 1'b0);
        check("reset_busy", busy, 32'h0);
        rst = 1'b0;
        #1;
        // round robin, first grant to req0
        for (int k = 0; k < 4; k++) begin
            check("rr_ready", req_ready, exp_r[k]);
            if (k > 0) begin
                check("rr_rf_we", rf_we, 1'b1);
                check("rr_waddr", rf_waddr, exp_a[k-1]);
            end
            tick();
            #1;
        end
        drive(2'b00, 5'd5, 32'h11, 5'd6, 32'h22);
        #1;
        check("rr_last_we", rf_we, 1'b1);
        check("rr_last_waddr", rf_waddr, 5'd6);
        check("rr_last_wdata", rf_wdata, 32'h22);

        // x0 drop
        drive(2'b10, 5'd5, 32'h11, 5'd0, 32'hDEAD);
        #1;
        check("x0_ready", req_ready, 2'b10);
        tick();
        drive(2'b00, 5'd5, 32'h11, 5'd0, 32'hDEAD);
        #1;
        check("x0_rf_we", rf_we, 1'b0);
        check("x0_waddr_hold", rf_waddr, 5'd6);
        check("x0_wdata_hold", rf_wdata, 32'h22);

        // scoreboard: claim x7, later grant x7
        claim_valid = 1'b1; claim_rd = 5'd7;
        tick();
        claim_valid = 1'b0;
        #1;
        check("sb_set", busy[7], 1'b1);
        tick();
        tick();
        drive(2'b01, 5'd7, 32'h77, 5'd6, 32'h22);
        #1;
        check("sb_grant_ready", req_ready, 2'b01);
        check("sb_still_busy", busy[7], 1'b1);
        tick();
        drive(2'b00, 5'd7, 32'h77, 5'd6, 32'h22);
        #1;
        check("sb_cleared", busy, 32'h0);
        check("sb_write_addr", rf_waddr, 5'd7);
        check("sb_write_data", rf_wdata, 32'h77);
        // claim and grant of x7 in the same cycle: set wins
        drive(2'b01, 5'd7, 32'h78, 5'd6, 32'h22);
        claim_valid = 1'b1; claim_rd = 5'd7;
        tick();
        drive(2'b00, 5'd7, 32'h78, 5'd6, 32'h22);
        claim_valid = 1'b0;
        #1;
        check("sb_set_wins", busy, 32'h80);
        // claim of x0 leaves busy unchanged
        claim_valid = 1'b1; claim_rd = 5'd0;
        tick();
        claim_valid = 1'b0;
        #1;
        check("sb_claim_x0", busy, 32'h80);

        // async reset mid-cycle while a write is on the port; ptr is 1 here
        drive(2'b01, 5'd9, 32'h99, 5'd6, 32'h22);
        tick();
        drive(2'b11, 5'd9, 32'h99, 5'd6, 32'h22);
        #1;
        check("ar_pre_we", rf_we, 1'b1);
        check("ar_pre_busy", busy, 32'h80);
        check("ar_pre_ready", req_ready, 2'b10);
        #1 rst = 1'b1;
        #1;
        check("ar_rf_we", rf_we, 1'b0);
        check("ar_busy", busy, 32'h0);
        check("ar_ready", req_ready, 2'b00);
        check("ar_waddr", rf_waddr, 5'd0);
        #2 rst = 1'b0;
        #1;
        check("ar_ptr_cleared", req_ready, 2'b01);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        tick();

`ifdef RF_WR_ARB_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(2'b01, 5'd3, 32'h33, 5'd4, 32'h44);
        for (int n = 0; n < 70000; n++) tick();
        drive(2'b00, 5'd3, 32'h33, 5'd4, 32'h44);
        tick();
        check("perf_field0", perf_grant_cnt[15:0], 16'hFFFF);
        check("perf_field1", perf_grant_cnt[31:16], 16'h0000);
        check("perf_model0", perf_grant_cnt[15:0], 16'(cnt_m[0]));
        check("perf_model1", perf_grant_cnt[31:16], 16'(cnt_m[1]));
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
